// File: rtl/add_sub.sv
// 32-bit add/subtract unit with a single registered result stage.
// Every opcode reduces to {1'b0,X} + {1'b0,Y} + Cin; ADC feeds back the registered carry.
module add_sub (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  select,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic [32:0] temp_output_to_check_carry,
  output logic        carry,
  output logic        zero
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SUM_W  = DATA_W + 1;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_RSUB = 3'b100,
    OP_NEG  = 3'b101,
    OP_PASS = 3'b110,
    OP_ADC  = 3'b111
  } op_e;

  logic [SUM_W-1:0]  r_sum;
  logic              r_zero;

  logic [DATA_W-1:0] w_x;
  logic [DATA_W-1:0] w_y;
  logic              w_cin;
  logic [SUM_W-1:0]  w_sum;
  logic              w_zero;

  // Operand steering: pick X, Y and carry-in for the shared adder
  always_comb begin
    w_x   = a;
    w_y   = '0;
    w_cin = 1'b0;
    unique case (op_e'(select))
      OP_ADD:  begin w_x = a;   w_y = b;  w_cin = 1'b0;  end
      OP_SUB:  begin w_x = a;   w_y = ~b; w_cin = 1'b1;  end
      OP_INC:  begin w_x = a;   w_y = '0; w_cin = 1'b1;  end
      OP_DEC:  begin w_x = a;   w_y = '1; w_cin = 1'b0;  end
      OP_RSUB: begin w_x = b;   w_y = ~a; w_cin = 1'b1;  end
      OP_NEG:  begin w_x = '0;  w_y = ~a; w_cin = 1'b1;  end
      OP_PASS: begin w_x = a;   w_y = '0; w_cin = 1'b0;  end
      OP_ADC:  begin w_x = a;   w_y = b;  w_cin = r_sum[DATA_W]; end
      default: begin w_x = a;   w_y = '0; w_cin = 1'b0;  end
    endcase
  end

  assign w_sum  = {1'b0, w_x} + {1'b0, w_y} + SUM_W'(w_cin);
  assign w_zero = (w_sum[DATA_W-1:0] == '0);

  // Result register; zero flag reflects the 32-bit result only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_zero <= 1'b1;
    end else begin
      r_sum  <= w_sum;
      r_zero <= w_zero;
    end
  end

  assign temp_output_to_check_carry = r_sum;
  assign out                        = r_sum[DATA_W-1:0];
  assign carry                      = r_sum[DATA_W];
  assign zero                       = r_zero;

endmodule

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub: directed vector table, reset corners, random ops vs. arithmetic model.
module tb_add_sub;

  logic        clk;
  logic        rst;
  logic [2:0]  select;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] out;
  logic [32:0] temp_output_to_check_carry;
  logic        carry;
  logic        zero;

  int tests;
  int fails;
  logic m_carry;

  add_sub dut (
    .clk                        (clk),
    .rst                        (rst),
    .select                     (select),
    .a                          (a),
    .b                          (b),
    .out                        (out),
    .temp_output_to_check_carry (temp_output_to_check_carry),
    .carry                      (carry),
    .zero                       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e_out;
    logic        e_carry;
    logic        e_zero;
  } vec_t;

  vec_t vecs[14];

  // Reference: plain unsigned arithmetic on 64-bit values
  function automatic logic [32:0] ref_op(input logic [2:0] s, input logic [31:0] av,
                                         input logic [31:0] bv, input logic c);
    longint unsigned ua, ub, r;
    logic cy;
    ua = 64'(av);
    ub = 64'(bv);
    r  = 0;
    cy = 1'b0;
    case (s)
      3'd0: begin r = ua + ub;           cy = (r >= 64'h1_0000_0000); end
      3'd1: begin r = ua - ub;           cy = (ua >= ub);             end
      3'd2: begin r = ua + 1;            cy = (r >= 64'h1_0000_0000); end
      3'd3: begin r = ua - 1;            cy = (ua != 0);              end
      3'd4: begin r = ub - ua;           cy = (ub >= ua);             end
      3'd5: begin r = 0 - ua;            cy = (ua == 0);              end
      3'd6: begin r = ua;                cy = 1'b0;                   end
      default: begin r = ua + ub + 64'(c); cy = (r >= 64'h1_0000_0000); end
    endcase
    return {cy, 32'(r)};
  endfunction

  task automatic check(input string name, input logic [31:0] e_out,
                       input logic e_carry, input logic e_zero);
    tests++;
    if (out !== e_out || carry !== e_carry || zero !== e_zero ||
        temp_output_to_check_carry !== {e_carry, e_out}) begin
      fails++;
      $display("FAIL %s: got out=%h carry=%b zero=%b temp=%h, want out=%h carry=%b zero=%b temp=%h",
               name, out, carry, zero, temp_output_to_check_carry,
               e_out, e_carry, e_zero, {e_carry, e_out});
    end
  endtask

  // One operation: drive at negedge, check 1 ns after the capturing edge
  task automatic step(input string name, input logic [2:0] s, input logic [31:0] av,
                      input logic [31:0] bv, input logic [31:0] e_out,
                      input logic e_carry, input logic e_zero);
    @(negedge clk);
    select = s;
    a      = av;
    b      = bv;
    @(posedge clk);
    #1;
    check(name, e_out, e_carry, e_zero);
    m_carry = e_carry;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 3));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [32:0] exp;
    logic [2:0]  rs;
    logic [31:0] ra, rb;
    tests   = 0;
    fails   = 0;
    m_carry = 1'b0;

    vecs[0]  = '{3'b000, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1'b1, 1'b1};
    vecs[1]  = '{3'b001, 32'd5,         32'd7,        32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2]  = '{3'b001, 32'd7,         32'd7,        32'h0000_0000, 1'b1, 1'b1};
    vecs[3]  = '{3'b000, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 1'b1, 1'b0};
    vecs[4]  = '{3'b111, 32'd3,         32'd4,        32'h0000_0008, 1'b0, 1'b0};
    vecs[5]  = '{3'b010, 32'd0,         32'd9,        32'h0000_0001, 1'b0, 1'b0};
    vecs[6]  = '{3'b011, 32'd0,         32'd9,        32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[7]  = '{3'b101, 32'd0,         32'd9,        32'h0000_0000, 1'b1, 1'b1};
    vecs[8]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0};
    vecs[9]  = '{3'b100, 32'd3,         32'd10,       32'h0000_0007, 1'b1, 1'b0};
    vecs[10] = '{3'b010, 32'hFFFF_FFFF, 32'd0,        32'h0000_0000, 1'b1, 1'b1};
    vecs[11] = '{3'b111, 32'd0,         32'd0,        32'h0000_0001, 1'b0, 1'b0};
    vecs[12] = '{3'b101, 32'd1,         32'd0,        32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[13] = '{3'b011, 32'd1,         32'd0,        32'h0000_0000, 1'b1, 1'b1};

    // Reset held 100 ns across several edges
    rst    = 1'b1;
    select = 3'b000;
    a      = '0;
    b      = '0;
    #1;
    check("reset_start", 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      #10;
      check("reset_hold", 32'h0, 1'b0, 1'b1);
    end
    @(negedge clk);
    rst = 1'b0;
    step("first_add_zero", 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Directed table, back-to-back one per cycle
    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b,
           vecs[i].e_out, vecs[i].e_carry, vecs[i].e_zero);
    end

    // Async reset between edges clears immediately and discards pending op
    step("pre_reset_carry", 3'b000, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    select = 3'b000;
    a      = 32'd5;
    b      = 32'd6;
    @(posedge clk);
    #1;
    check("pending_add", 32'd11, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_clear", 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("reset_over_edge", 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("after_release", 32'h0, 1'b0, 1'b1);
    m_carry = 1'b0;
    step("adc_after_reset", 3'b111, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);

    // Random ops against the arithmetic model
    for (int i = 0; i < 400; i++) begin
      rs  = 3'($urandom_range(0, 7));
      ra  = rnd_val();
      rb  = rnd_val();
      exp = ref_op(rs, ra, rb, m_carry);
      step($sformatf("rand%0d_op%0d", i, rs), rs, ra, rb, exp[31:0], exp[32],
           (exp[31:0] == 32'h0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
